// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA timing generator: standard modes, sync polarity
// encodings and the elaboration-time counter range check.
package vga_timing_pkg;

    typedef struct packed {
        int   h_visible;
        int   h_front;
        int   h_sync;
        int   h_back;
        int   v_visible;
        int   v_front;
        int   v_sync;
        int   v_back;
        logic h_pol;
        logic v_pol;
    } vga_mode_t;

    localparam logic POL_POS = 1'b1;
    localparam logic POL_NEG = 1'b0;

    localparam vga_mode_t MODE_800x600_75  = '{800, 16, 80, 160, 600, 1, 3, 21, POL_POS, POL_POS};
    localparam vga_mode_t MODE_640x480_60  = '{640, 16, 96, 48, 480, 10, 2, 33, POL_NEG, POL_NEG};
    localparam vga_mode_t MODE_1024x768_60 = '{1024, 24, 136, 160, 768, 3, 6, 29, POL_NEG, POL_NEG};

    // An axis total must be at least one and fit in a CNT_W-bit counter.
    function automatic bit axis_fits(input int total, input int cnt_w);
        return (cnt_w > 0) && (cnt_w < 31) && (total >= 1) && (total <= (1 << cnt_w));
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle driven by vga_timing_gen towards the fetch/shift logic.
interface vga_timing_gen_if #(
    parameter int CNT_W = 11
);
    logic             hsync;
    logic             vsync;
    logic             display_en;
    logic [CNT_W-1:0] counter_x;
    logic [CNT_W-1:0] counter_y;
    logic             line_start;
    logic             frame_start;
    logic             vblank;
    logic [CNT_W-1:0] fetch_x;
    logic [CNT_W-1:0] fetch_y;
    logic             fetch_en;

    modport master (
        output hsync, vsync, display_en, counter_x, counter_y,
               line_start, frame_start, vblank, fetch_x, fetch_y, fetch_en
    );

    modport slave (
        input hsync, vsync, display_en, counter_x, counter_y,
              line_start, frame_start, vblank, fetch_x, fetch_y, fetch_en
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter with terminal count plus sync and
// visible-region decodes of the current position.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VISIBLE = 800,
    parameter int FRONT   = 16,
    parameter int SYNC    = 80,
    parameter int BACK    = 160,
    parameter int CNT_W   = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count,
    output logic             o_tc,
    output logic             o_sync,
    output logic             o_visible
);

    localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;

    if (!axis_fits(TOTAL, CNT_W)) begin : g_range_check
        $error("vga_axis_counter: total %0d does not fit in %0d bits", TOTAL, CNT_W);
    end

    // Decodes use one extra bit so a sync pulse ending exactly at 2**CNT_W still works.
    localparam logic [CNT_W:0] LAST_X     = (CNT_W+1)'(TOTAL - 1);
    localparam logic [CNT_W:0] SYNC_BEG_X = (CNT_W+1)'(VISIBLE + FRONT);
    localparam logic [CNT_W:0] SYNC_END_X = (CNT_W+1)'(VISIBLE + FRONT + SYNC);
    localparam logic [CNT_W:0] VIS_END_X  = (CNT_W+1)'(VISIBLE);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W:0]   w_count_x;

    assign w_count_x = {1'b0, r_count};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_tc ? '0 : r_count + 1'b1;
        end
    end

    assign o_count   = r_count;
    assign o_tc      = (w_count_x == LAST_X);
    assign o_sync    = (w_count_x >= SYNC_BEG_X) && (w_count_x < SYNC_END_X);
    assign o_visible = (w_count_x < VIS_END_X);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/SVGA sync generator with pixel clock-enable, registered
// outputs, line/frame strobes and lookahead fetch coordinates.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_VISIBLE = MODE_800x600_75.h_visible,
    parameter int   H_FRONT   = MODE_800x600_75.h_front,
    parameter int   H_SYNC    = MODE_800x600_75.h_sync,
    parameter int   H_BACK    = MODE_800x600_75.h_back,
    parameter int   V_VISIBLE = MODE_800x600_75.v_visible,
    parameter int   V_FRONT   = MODE_800x600_75.v_front,
    parameter int   V_SYNC    = MODE_800x600_75.v_sync,
    parameter int   V_BACK    = MODE_800x600_75.v_back,
    parameter logic H_POL     = MODE_800x600_75.h_pol,
    parameter logic V_POL     = MODE_800x600_75.v_pol,
    parameter int   CNT_W     = 11,
    parameter int   LOOKAHEAD = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    vga_timing_gen_if.master vid
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if (LOOKAHEAD < 0 || LOOKAHEAD > H_TOTAL - 1) begin : g_lookahead_check
        $error("vga_timing_gen: LOOKAHEAD %0d outside 0..%0d", LOOKAHEAD, H_TOTAL - 1);
    end

    localparam logic [CNT_W:0] H_TOTAL_X   = (CNT_W+1)'(H_TOTAL);
    localparam logic [CNT_W:0] H_VISIBLE_X = (CNT_W+1)'(H_VISIBLE);
    localparam logic [CNT_W:0] V_VISIBLE_X = (CNT_W+1)'(V_VISIBLE);
    localparam logic [CNT_W:0] LOOKAHEAD_X = (CNT_W+1)'(LOOKAHEAD);

    logic [CNT_W-1:0] w_hc, w_vc;
    logic             w_h_tc, w_v_tc, w_h_sync, w_v_sync, w_h_vis, w_v_vis;

    vga_axis_counter #(
        .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .CNT_W(CNT_W)
    ) u_h_axis (
        .clk(clk), .reset(reset), .i_en(ce),
        .o_count(w_hc), .o_tc(w_h_tc), .o_sync(w_h_sync), .o_visible(w_h_vis)
    );

    vga_axis_counter #(
        .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .CNT_W(CNT_W)
    ) u_v_axis (
        .clk(clk), .reset(reset), .i_en(ce && w_h_tc),
        .o_count(w_vc), .o_tc(w_v_tc), .o_sync(w_v_sync), .o_visible(w_v_vis)
    );

    // Lookahead never exceeds one line, so at most one wrap into the next line.
    logic [CNT_W:0]   w_fx_sum;
    logic             w_fx_wrap;
    logic [CNT_W-1:0] w_fx, w_fy;
    logic             w_fe;

    always_comb begin
        w_fx_sum  = {1'b0, w_hc} + LOOKAHEAD_X;
        w_fx_wrap = (w_fx_sum >= H_TOTAL_X);
        w_fx      = w_fx_wrap ? CNT_W'(w_fx_sum - H_TOTAL_X) : w_fx_sum[CNT_W-1:0];
        w_fy      = w_vc;
        if (w_fx_wrap) begin
            w_fy = w_v_tc ? '0 : w_vc + 1'b1;
        end
        w_fe = ({1'b0, w_fx} < H_VISIBLE_X) && ({1'b0, w_fy} < V_VISIBLE_X);
    end

    logic             r_hsync, r_vsync, r_display_en, r_line_start, r_frame_start;
    logic             r_vblank, r_fetch_en;
    logic [CNT_W-1:0] r_counter_x, r_counter_y, r_fetch_x, r_fetch_y;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hsync       <= ~H_POL;
            r_vsync       <= ~V_POL;
            r_display_en  <= 1'b0;
            r_counter_x   <= '0;
            r_counter_y   <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_vblank      <= 1'b0;
            r_fetch_x     <= '0;
            r_fetch_y     <= '0;
            r_fetch_en    <= 1'b0;
        end else if (ce) begin
            r_hsync       <= w_h_sync ? H_POL : ~H_POL;
            r_vsync       <= w_v_sync ? V_POL : ~V_POL;
            r_display_en  <= w_h_vis && w_v_vis;
            r_counter_x   <= w_hc;
            r_counter_y   <= w_vc;
            r_line_start  <= (w_hc == '0);
            r_frame_start <= (w_hc == '0) && (w_vc == '0);
            r_vblank      <= !w_v_vis;
            r_fetch_x     <= w_fx;
            r_fetch_y     <= w_fy;
            r_fetch_en    <= w_fe;
        end
    end

    assign vid.hsync       = r_hsync;
    assign vid.vsync       = r_vsync;
    assign vid.display_en  = r_display_en;
    assign vid.counter_x   = r_counter_x;
    assign vid.counter_y   = r_counter_y;
    assign vid.line_start  = r_line_start;
    assign vid.frame_start = r_frame_start;
    assign vid.vblank      = r_vblank;
    assign vid.fetch_x     = r_fetch_x;
    assign vid.fetch_y     = r_fetch_y;
    assign vid.fetch_en    = r_fetch_en;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four parameterisations checked every cycle against a
// pixel-index reference model, plus directed period/width/boundary checks.
module tb_vga_timing_gen;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [10:0] cx;
        logic [10:0] cy;
        logic        ls;
        logic        fs;
        logic        vb;
        logic [10:0] fx;
        logic [10:0] fy;
        logic        fe;
    } obs_t;

    typedef struct packed {
        int hv, hf, hs, hb, vv, vf, vs, vb, hpol, vpol, la;
    } mode_t;

    localparam mode_t MA = '{8, 2, 2, 4, 4, 1, 1, 2, 1, 1, 3};
    localparam mode_t MB = '{8, 2, 2, 4, 4, 1, 1, 2, 0, 0, 2};
    localparam mode_t MC = '{800, 16, 80, 160, 600, 1, 3, 21, 1, 1, 2};
    localparam mode_t MD = '{8, 2, 6, 0, 4, 1, 1, 2, 1, 1, 0};

    logic       clk = 1'b0;
    logic [3:0] ceV = '0;
    logic [3:0] rstV = '0;
    int         nCe[4];
    int         testsRun = 0;
    int         failCount = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.CNT_W(4))  ifA ();
    vga_timing_gen_if #(.CNT_W(4))  ifB ();
    vga_timing_gen_if #(.CNT_W(11)) ifC ();
    vga_timing_gen_if #(.CNT_W(4))  ifD ();

    vga_timing_gen #(
        .H_VISIBLE(MA.hv), .H_FRONT(MA.hf), .H_SYNC(MA.hs), .H_BACK(MA.hb),
        .V_VISIBLE(MA.vv), .V_FRONT(MA.vf), .V_SYNC(MA.vs), .V_BACK(MA.vb),
        .H_POL(1'b1), .V_POL(1'b1), .CNT_W(4), .LOOKAHEAD(MA.la)
    ) dutA (.clk(clk), .reset(rstV[0]), .ce(ceV[0]), .vid(ifA));

    vga_timing_gen #(
        .H_VISIBLE(MB.hv), .H_FRONT(MB.hf), .H_SYNC(MB.hs), .H_BACK(MB.hb),
        .V_VISIBLE(MB.vv), .V_FRONT(MB.vf), .V_SYNC(MB.vs), .V_BACK(MB.vb),
        .H_POL(1'b0), .V_POL(1'b0), .CNT_W(4), .LOOKAHEAD(MB.la)
    ) dutB (.clk(clk), .reset(rstV[1]), .ce(ceV[1]), .vid(ifB));

    vga_timing_gen dutC (.clk(clk), .reset(rstV[2]), .ce(ceV[2]), .vid(ifC));

    vga_timing_gen #(
        .H_VISIBLE(MD.hv), .H_FRONT(MD.hf), .H_SYNC(MD.hs), .H_BACK(MD.hb),
        .V_VISIBLE(MD.vv), .V_FRONT(MD.vf), .V_SYNC(MD.vs), .V_BACK(MD.vb),
        .H_POL(1'b1), .V_POL(1'b1), .CNT_W(4), .LOOKAHEAD(MD.la)
    ) dutD (.clk(clk), .reset(rstV[3]), .ce(ceV[3]), .vid(ifD));

    obs_t obsA, obsB, obsC, obsD;

    assign obsA = {ifA.hsync, ifA.vsync, ifA.display_en, 11'(ifA.counter_x), 11'(ifA.counter_y),
                   ifA.line_start, ifA.frame_start, ifA.vblank, 11'(ifA.fetch_x), 11'(ifA.fetch_y), ifA.fetch_en};
    assign obsB = {ifB.hsync, ifB.vsync, ifB.display_en, 11'(ifB.counter_x), 11'(ifB.counter_y),
                   ifB.line_start, ifB.frame_start, ifB.vblank, 11'(ifB.fetch_x), 11'(ifB.fetch_y), ifB.fetch_en};
    assign obsC = {ifC.hsync, ifC.vsync, ifC.display_en, ifC.counter_x, ifC.counter_y,
                   ifC.line_start, ifC.frame_start, ifC.vblank, ifC.fetch_x, ifC.fetch_y, ifC.fetch_en};
    assign obsD = {ifD.hsync, ifD.vsync, ifD.display_en, 11'(ifD.counter_x), 11'(ifD.counter_y),
                   ifD.line_start, ifD.frame_start, ifD.vblank, 11'(ifD.fetch_x), 11'(ifD.fetch_y), ifD.fetch_en};

    function automatic obs_t pick(input int d);
        case (d)
            0:       return obsA;
            1:       return obsB;
            2:       return obsC;
            default: return obsD;
        endcase
    endfunction

    function automatic mode_t modeOf(input int d);
        case (d)
            0:       return MA;
            1:       return MB;
            2:       return MC;
            default: return MD;
        endcase
    endfunction

    // Reference: after n enabled cycles the outputs show linear pixel n-1 of the frame.
    function automatic obs_t model(input int n, input mode_t m);
        obs_t e;
        int ht, vt, p, x, y, lin, lx, ly;
        e = '0;
        if (n == 0) begin
            e.hs = !m.hpol[0];
            e.vs = !m.vpol[0];
            return e;
        end
        ht  = m.hv + m.hf + m.hs + m.hb;
        vt  = m.vv + m.vf + m.vs + m.vb;
        p   = (n - 1) % (ht * vt);
        x   = p % ht;
        y   = p / ht;
        lin = (p + m.la) % (ht * vt);
        lx  = lin % ht;
        ly  = lin / ht;
        e.cx = 11'(x);
        e.cy = 11'(y);
        e.hs = (x >= m.hv + m.hf && x < m.hv + m.hf + m.hs) ? m.hpol[0] : !m.hpol[0];
        e.vs = (y >= m.vv + m.vf && y < m.vv + m.vf + m.vs) ? m.vpol[0] : !m.vpol[0];
        e.de = (x < m.hv) && (y < m.vv);
        e.ls = (x == 0);
        e.fs = (p == 0);
        e.vb = (y >= m.vv);
        e.fx = 11'(lx);
        e.fy = 11'(ly);
        e.fe = (lx < m.hv) && (ly < m.vv);
        return e;
    endfunction

    task automatic checkOutput(input int d);
        obs_t got, exp;
        got = pick(d);
        exp = model(nCe[d], modeOf(d));
        testsRun++;
        assert (got === exp) else begin
            failCount++;
            $error("[TB] FAIL dut%0d_model n=%0d observed=%h expected=%h", d, nCe[d], got, exp);
        end
    endtask

    task automatic checkValue(input string tag, input int observed, input int expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive one clock for DUT d (others frozen), then sample 1 time unit after the edge.
    task automatic applyStimulus(input int d, input logic c, input logic r);
        ceV     = '0;
        rstV    = '0;
        ceV[d]  = c;
        rstV[d] = r;
        @(posedge clk);
        #1;
        if (r) nCe[d] = 0;
        else if (c) nCe[d]++;
        checkOutput(d);
    endtask

    initial begin
        int   first, period, seenFetch, found, runLen, hsWidth;
        logic prev;
        for (int i = 0; i < 4; i++) nCe[i] = 0;

        // Small mode, ce always high: frame period and lookahead wrap.
        for (int k = 0; k < 3; k++) applyStimulus(0, 1'b1, 1'b1);
        prev = 1'b0; first = -1; period = -1; seenFetch = 0;
        for (int k = 0; k < 260; k++) begin
            applyStimulus(0, 1'b1, 1'b0);
            if (obsA.fs && !prev) begin
                if (first >= 0 && period < 0) period = k - first;
                if (first < 0) first = k;
            end
            prev = obsA.fs;
            if (obsA.cx == 11'd14 && obsA.cy == 11'd7 && seenFetch == 0) begin
                seenFetch = 1;
                checkValue("fetch_wrap_x", int'(obsA.fx), 1);
                checkValue("fetch_wrap_y", int'(obsA.fy), 0);
            end
        end
        checkValue("frame_period_ce1", period, 128);
        checkValue("fetch_wrap_seen", seenFetch, 1);

        // ce one cycle in three: frame period stretches to 384 clocks.
        for (int k = 0; k < 2; k++) applyStimulus(0, 1'b1, 1'b1);
        prev = 1'b0; first = -1; period = -1;
        for (int k = 0; k < 800; k++) begin
            applyStimulus(0, (k % 3) == 0, 1'b0);
            if (obsA.fs && !prev) begin
                if (first >= 0 && period < 0) period = k - first;
                if (first < 0) first = k;
            end
            prev = obsA.fs;
        end
        checkValue("frame_period_ce3", period, 384);

        // Random ce pattern.
        for (int k = 0; k < 400; k++) applyStimulus(0, 1'($urandom_range(0, 1)), 1'b0);

        // Mid-frame reset at (6,2), then restart at (0,0).
        found = 0;
        for (int k = 0; k < 200 && found == 0; k++) begin
            applyStimulus(0, 1'b1, 1'b0);
            if (obsA.cx == 11'd6 && obsA.cy == 11'd2) found = 1;
        end
        checkValue("reach_6_2", found, 1);
        applyStimulus(0, 1'b1, 1'b1);
        checkValue("midreset_hsync", int'(obsA.hs), 0);
        applyStimulus(0, 1'b1, 1'b0);
        checkValue("restart_frame_start", int'(obsA.fs), 1);
        checkValue("restart_display_en", int'(obsA.de), 1);

        // Negative polarity: inactive-high syncs during reset.
        for (int k = 0; k < 3; k++) applyStimulus(1, 1'b1, 1'b1);
        checkValue("negpol_reset_hsync", int'(obsB.hs), 1);
        checkValue("negpol_reset_vsync", int'(obsB.vs), 1);
        for (int k = 0; k < 260; k++) applyStimulus(1, 1'b1, 1'b0);

        // Default 800x600: line period and hsync width.
        for (int k = 0; k < 2; k++) applyStimulus(2, 1'b1, 1'b1);
        prev = 1'b0; first = -1; period = -1; runLen = 0; hsWidth = -1;
        for (int k = 0; k < 3300; k++) begin
            applyStimulus(2, 1'b1, 1'b0);
            if (obsC.ls && !prev) begin
                if (first >= 0 && period < 0) period = k - first;
                if (first < 0) first = k;
            end
            prev = obsC.ls;
            if (obsC.hs) runLen++;
            else begin
                if (runLen > 0 && hsWidth < 0) hsWidth = runLen;
                runLen = 0;
            end
        end
        checkValue("line_period_800", period, 1056);
        checkValue("hsync_width_800", hsWidth, 80);

        // Sync pulse running to the end of the line (no back porch).
        for (int k = 0; k < 2; k++) applyStimulus(3, 1'b1, 1'b1);
        for (int k = 0; k < 300; k++) applyStimulus(3, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
